// File: rtl/axis_in_data_unpackage.sv
// AXI4-Stream slave that buffers 32-bit words in a small FIFO and serialises each
// word LSB-first onto a 1-bit valid/ready stream, flagging layer ends from TLAST.
module axis_in_data_unpackage #(
   parameter int unsigned FIFO_DEPTH           = 4,
   parameter int unsigned C_S_AXIS_TDATA_WIDTH = 32
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   S_AXIS_TDATA,
   input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] S_AXIS_TSTRB,
   input  logic                          S_AXIS_TVALID,
   input  logic                          S_AXIS_TLAST,
   output logic                          S_AXIS_TREADY,
   output logic                          out_valid,
   output logic                          out_data,
   output logic                          out_last,
   input  logic                          out_ready,
   output logic                          layer_finish,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
   localparam int unsigned CntW = $clog2(C_S_AXIS_TDATA_WIDTH);
   localparam int unsigned EntW = C_S_AXIS_TDATA_WIDTH + 1;

   localparam logic StIdle  = 1'b0;
   localparam logic StShift = 1'b1;

   localparam logic [PtrW-1:0] PtrOne    = PtrW'(1);
   localparam logic [PtrW:0]   CountOne  = (PtrW + 1)'(1);
   localparam logic [PtrW:0]   CountFull = (PtrW + 1)'(FIFO_DEPTH);
   localparam logic [CntW-1:0] BitOne    = CntW'(1);
   localparam logic [CntW-1:0] BitLast   = CntW'(C_S_AXIS_TDATA_WIDTH - 1);

   logic [EntW-1:0] mem_q [FIFO_DEPTH];
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PtrW:0]   count_q, count_d;

   logic                            state_q, state_d;
   logic [C_S_AXIS_TDATA_WIDTH-1:0] shreg_q, shreg_d;
   logic                            last_q, last_d;
   logic [CntW-1:0]                 bitcnt_q, bitcnt_d;
   logic                            layer_finish_q, layer_finish_d;

   logic            push, pop, fire, word_done, fifo_empty;
   logic [EntW-1:0] head;
   logic            unused_tstrb;

   // Strobes carry no meaning here: every word is emitted as a full word.
   assign unused_tstrb = ^S_AXIS_TSTRB;

   assign fifo_empty    = (count_q == '0);
   assign S_AXIS_TREADY = !rst && (count_q != CountFull);
   assign push          = S_AXIS_TVALID && S_AXIS_TREADY;
   assign head          = mem_q[rd_ptr_q];

   assign fire      = (state_q == StShift) && out_ready;
   assign word_done = fire && (bitcnt_q == BitLast);
   // Reload on the final bit's edge so consecutive words stream without a bubble.
   assign pop       = !fifo_empty && ((state_q == StIdle) || word_done);

   assign out_valid    = (state_q == StShift);
   assign out_data     = shreg_q[0];
   assign out_last     = out_valid && last_q && (bitcnt_q == BitLast);
   assign layer_finish = layer_finish_q;
   assign fifo_count   = count_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + PtrOne;
      if (pop)  rd_ptr_d = rd_ptr_q + PtrOne;
      unique case ({push, pop})
         2'b10:   count_d = count_q + CountOne;
         2'b01:   count_d = count_q - CountOne;
         default: count_d = count_q;
      endcase
   end

   always_comb begin
      state_d        = state_q;
      shreg_d        = shreg_q;
      last_d         = last_q;
      bitcnt_d       = bitcnt_q;
      layer_finish_d = fire && out_last;
      if (pop) begin
         shreg_d  = head[C_S_AXIS_TDATA_WIDTH-1:0];
         last_d   = head[EntW-1];
         bitcnt_d = '0;
         state_d  = StShift;
      end else if (fire) begin
         shreg_d  = shreg_q >> 1;
         bitcnt_d = bitcnt_q + BitOne;
         if (word_done) state_d = StIdle;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= {S_AXIS_TLAST, S_AXIS_TDATA};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         count_q        <= '0;
         state_q        <= StIdle;
         shreg_q        <= '0;
         last_q         <= 1'b0;
         bitcnt_q       <= '0;
         layer_finish_q <= 1'b0;
      end else begin
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         count_q        <= count_d;
         state_q        <= state_d;
         shreg_q        <= shreg_d;
         last_q         <= last_d;
         bitcnt_q       <= bitcnt_d;
         layer_finish_q <= layer_finish_d;
      end
   end

endmodule

// File: tb/tb_axis_in_data_unpackage.sv
// Randomised scoreboard bench: accepted words are expanded into expected bits and
// a negedge monitor compares every consumed bit plus the layer_finish pulses.
module tb_axis_in_data_unpackage;

   localparam int Depth = 4;

   logic        clk;
   logic        rst;
   logic [31:0] S_AXIS_TDATA;
   logic [3:0]  S_AXIS_TSTRB;
   logic        S_AXIS_TVALID;
   logic        S_AXIS_TLAST;
   logic        S_AXIS_TREADY;
   logic        out_valid;
   logic        out_data;
   logic        out_last;
   logic        out_ready;
   logic        layer_finish;
   logic [2:0]  fifo_count;

   axis_in_data_unpackage #(
      .FIFO_DEPTH          (Depth),
      .C_S_AXIS_TDATA_WIDTH(32)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .S_AXIS_TDATA (S_AXIS_TDATA),
      .S_AXIS_TSTRB (S_AXIS_TSTRB),
      .S_AXIS_TVALID(S_AXIS_TVALID),
      .S_AXIS_TLAST (S_AXIS_TLAST),
      .S_AXIS_TREADY(S_AXIS_TREADY),
      .out_valid    (out_valid),
      .out_data     (out_data),
      .out_last     (out_last),
      .out_ready    (out_ready),
      .layer_finish (layer_finish),
      .fifo_count   (fifo_count)
   );

   int checks   = 0;
   int failures = 0;

   logic [1:0] exp_q[$];   // {last, data} per expected bit
   int  consumed  = 0;
   int  lf_count  = 0;
   int  gaps      = 0;
   int  max_count = 0;
   bit  gap_watch = 0;
   bit  ready_mode = 0;    // 0: always ready, 1: random backpressure

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         out_ready = ready_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Monitor / scoreboard
   initial begin
      logic       fin_next;
      logic       stall_prev;
      logic       prev_d, prev_l;
      logic [1:0] e;
      fin_next   = 1'b0;
      stall_prev = 1'b0;
      prev_d     = 1'b0;
      prev_l     = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            fin_next   = 1'b0;
            stall_prev = 1'b0;
         end else begin
            check("tready_rule", 32'(S_AXIS_TREADY), 32'(fifo_count != 3'(Depth)));
            check("layer_finish", 32'(layer_finish), 32'(fin_next));
            if (stall_prev) begin
               check("stall_valid", 32'(out_valid), 32'd1);
               check("stall_data", 32'(out_data), 32'(prev_d));
               check("stall_last", 32'(out_last), 32'(prev_l));
            end
            if (layer_finish === 1'b1) lf_count++;
            if (int'(fifo_count) > max_count) max_count = int'(fifo_count);
            if (gap_watch && out_valid !== 1'b1 && exp_q.size() != 0) gaps++;
            fin_next = 1'b0;
            if (out_valid === 1'b1 && out_ready) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_bit actual=%0b required=none", out_data);
               end else begin
                  e = exp_q.pop_front();
                  check("bit_data", 32'(out_data), 32'(e[0]));
                  check("bit_last", 32'(out_last), 32'(e[1]));
                  fin_next = e[1];
               end
               consumed++;
            end
            stall_prev = (out_valid === 1'b1) && !out_ready;
            prev_d     = out_data;
            prev_l     = out_last;
         end
      end
   end

   // Offer one word; once accepted, its bits LSB-first join the expected stream.
   task automatic send_word(input logic [31:0] d, input logic l);
      int  n  = 0;
      bit  hs = 0;
      S_AXIS_TDATA  = d;
      S_AXIS_TLAST  = l;
      S_AXIS_TSTRB  = 4'($urandom);
      S_AXIS_TVALID = 1'b1;
      while (!hs && n < 400) begin
         @(negedge clk);
         hs = S_AXIS_TREADY;
         @(posedge clk);
         #1;
         n++;
      end
      S_AXIS_TVALID = 1'b0;
      checks++;
      if (!hs) begin
         failures++;
         $display("FAIL handshake_timeout actual=0 required=1 data=%08h", d);
      end else begin
         for (int i = 0; i < 32; i++) exp_q.push_back({l && (i == 31), d[i]});
      end
   endtask

   task automatic drain(input int bound);
      int n = 0;
      while (exp_q.size() != 0 && n < bound) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("drain_remaining", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      S_AXIS_TVALID = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int base;
      logic [31:0] words[4];
      bit          bits[97];
      rst           = 1'b1;
      S_AXIS_TDATA  = '0;
      S_AXIS_TSTRB  = '0;
      S_AXIS_TVALID = 1'b0;
      S_AXIS_TLAST  = 1'b0;

      // Reset state
      @(posedge clk);
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_out_last", 32'(out_last), 32'd0);
      check("rst_layer_finish", 32'(layer_finish), 32'd0);
      check("rst_fifo_count", 32'(fifo_count), 32'd0);
      check("rst_tready", 32'(S_AXIS_TREADY), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle(2);

      // 1: single word, latency from idle
      send_word(32'h12345678, 1'b1);
      check("s1_valid_at_accept", 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;
      check("s1_valid_next", 32'(out_valid), 32'd1);
      lf_count = 0;
      drain(200);
      check("s1_lf_pulses", 32'(lf_count), 32'd1);

      // 2: back-to-back fill, no gaps, FIFO reaches full
      lf_count  = 0;
      max_count = 0;
      gaps      = 0;
      fork
         begin
            send_word(32'hAAAAAAAA, 1'b0);
            send_word(32'hFFFFFFFF, 1'b0);
            send_word(32'h00000000, 1'b0);
            send_word(32'h9ABCDEF0, 1'b1);
            send_word(32'h12345678, 1'b0);
         end
         begin
            int w = 0;
            while (out_valid !== 1'b1 && w < 100) begin
               @(posedge clk);
               #1;
               w++;
            end
            gap_watch = 1'b1;
         end
      join
      drain(400);
      gap_watch = 1'b0;
      check("s2_gaps", 32'(gaps), 32'd0);
      check("s2_max_count", 32'(max_count), 32'(Depth));
      check("s2_lf_pulses", 32'(lf_count), 32'd1);

      // 3: downstream backpressure
      ready_mode = 1'b1;
      send_word(32'h98765432, 1'b1);
      drain(2000);
      ready_mode = 1'b0;
      idle(2);

      // 4: upstream gaps, each word starts from idle
      for (int k = 0; k < 3; k++) begin
         send_word($urandom, 1'($urandom_range(0, 1)));
         check("s4_valid_at_accept", 32'(out_valid), 32'd0);
         @(posedge clk);
         #1;
         check("s4_valid_next", 32'(out_valid), 32'd1);
         idle(38);
         check("s4_idle_between", 32'(out_valid), 32'd0);
      end
      drain(100);

      // 5: reset mid-word with two words queued
      base = consumed;
      send_word(32'hCAFEF00D, 1'b1);
      send_word(32'h11112222, 1'b0);
      send_word(32'h33334444, 1'b1);
      while (consumed < base + 10) begin
         @(posedge clk);
         #1;
      end
      check("s5_count_before_rst", 32'(fifo_count), 32'd2);
      rst = 1'b1;
      exp_q.delete();
      @(posedge clk);
      #1;
      check("s5_out_valid", 32'(out_valid), 32'd0);
      check("s5_out_data", 32'(out_data), 32'd0);
      check("s5_out_last", 32'(out_last), 32'd0);
      check("s5_layer_finish", 32'(layer_finish), 32'd0);
      check("s5_fifo_count", 32'(fifo_count), 32'd0);
      check("s5_tready", 32'(S_AXIS_TREADY), 32'd0);
      rst = 1'b0;
      lf_count = 0;
      idle(3);
      check("s5_no_lf_after_rst", 32'(lf_count), 32'd0);
      send_word(32'h0F1E2D3C, 1'b1);
      drain(200);

      // 6: loopback of an outbound packer: 97 bits zero-padded into 4 words
      for (int i = 0; i < 97; i++) bits[i] = 1'($urandom_range(0, 1));
      for (int j = 0; j < 4; j++) begin
         words[j] = '0;
         for (int i = 0; i < 32; i++)
            if (32 * j + i < 97) words[j][i] = bits[32 * j + i];
      end
      lf_count = 0;
      for (int j = 0; j < 4; j++) send_word(words[j], j == 3);
      drain(400);
      check("s6_lf_pulses", 32'(lf_count), 32'd1);

      // Random mix: random data, TLAST, gaps and backpressure
      ready_mode = 1'b1;
      for (int k = 0; k < 20; k++) begin
         send_word($urandom, $urandom_range(0, 3) == 0);
         idle($urandom_range(0, 3));
      end
      drain(5000);
      ready_mode = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
